// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port main-memory arbiter.
//   state_e : arbiter FSM encoding (IDLE, GRANT0, GRANT1)
//   PORT0/1 : requester indices (0 = instruction cache, 1 = data cache)
package mem_arbiter_pkg;

  localparam int unsigned ST_W = 2;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_req_mux.sv
// 2:1 request selector: picks {op, address, writedata} of the grant winner.
//   sel_i                : winning port index
//   rk_read_i/rk_write_i : requester strobes; read wins when both are high
//   rk_addr_i/rk_wdata_i : requester address and write block
//   rd_c/wr_c/addr_c/wdata_c : selected transaction (combinational)
module arb_req_mux
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              sel_i,
  input  logic              r0_read_i,
  input  logic              r0_write_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [DATA_W-1:0] r0_wdata_i,
  input  logic              r1_read_i,
  input  logic              r1_write_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [DATA_W-1:0] r1_wdata_i,
  output logic              rd_c,
  output logic              wr_c,
  output logic [ADDR_W-1:0] addr_c,
  output logic [DATA_W-1:0] wdata_c
);

  // A simultaneous read+write collapses to a read.
  always_comb begin
    rd_c    = r0_read_i;
    wr_c    = r0_write_i & ~r0_read_i;
    addr_c  = r0_addr_i;
    wdata_c = r0_wdata_i;
    if (sel_i == PORT1) begin
      rd_c    = r1_read_i;
      wr_c    = r1_write_i & ~r1_read_i;
      addr_c  = r1_addr_i;
      wdata_c = r1_wdata_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache
// (port 0) and the D-cache (port 1).
//   CLK, RESET (async, active low)
//   Rk_READ/Rk_WRITE/Rk_ADDRESS/Rk_WRITEDATA : requester k transaction
//   Rk_BUSYWAIT : requester k stall, drops for one cycle on completion
//   READDATA    : memory read block, passed straight through
//   MEM_*       : registered memory strobes/address/data, MEM_READDATA and
//                 MEM_BUSYWAIT from memory
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              R0_READ,
  input  logic              R0_WRITE,
  input  logic [ADDR_W-1:0] R0_ADDRESS,
  input  logic [DATA_W-1:0] R0_WRITEDATA,
  output logic              R0_BUSYWAIT,
  input  logic              R1_READ,
  input  logic              R1_WRITE,
  input  logic [ADDR_W-1:0] R1_ADDRESS,
  input  logic [DATA_W-1:0] R1_WRITEDATA,
  output logic              R1_BUSYWAIT,
  output logic [DATA_W-1:0] READDATA,
  output logic              MEM_READ,
  output logic              MEM_WRITE,
  output logic [ADDR_W-1:0] MEM_ADDRESS,
  output logic [DATA_W-1:0] MEM_WRITEDATA,
  input  logic [DATA_W-1:0] MEM_READDATA,
  input  logic              MEM_BUSYWAIT
);

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              started_q, started_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              req0_c, req1_c, win_c, done_c;
  logic              sel_rd_c, sel_wr_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_wdata_c;

  assign req0_c = R0_READ | R0_WRITE;
  assign req1_c = R1_READ | R1_WRITE;
  // On a tie the port that did not win last time goes next.
  assign win_c  = (req0_c & req1_c) ? ~last_grant_q : req1_c;
  // started guards against a completion seen before memory ever went busy.
  assign done_c = started_q & ~MEM_BUSYWAIT;

  arb_req_mux #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req_mux (
    .sel_i      (win_c),
    .r0_read_i  (R0_READ),
    .r0_write_i (R0_WRITE),
    .r0_addr_i  (R0_ADDRESS),
    .r0_wdata_i (R0_WRITEDATA),
    .r1_read_i  (R1_READ),
    .r1_write_i (R1_WRITE),
    .r1_addr_i  (R1_ADDRESS),
    .r1_wdata_i (R1_WRITEDATA),
    .rd_c       (sel_rd_c),
    .wr_c       (sel_wr_c),
    .addr_c     (sel_addr_c),
    .wdata_c    (sel_wdata_c)
  );

  // State and MEM_* registers.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      last_grant_q <= PORT1;
      started_q    <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      started_q    <= started_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Next-state: grant from IDLE, track the memory handshake while granted.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    started_d    = started_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req0_c | req1_c) begin
          state_d     = (win_c == PORT1) ? ST_GRANT1 : ST_GRANT0;
          started_d   = 1'b0;
          mem_read_d  = sel_rd_c;
          mem_write_d = sel_wr_c;
          mem_addr_d  = sel_addr_c;
          mem_wdata_d = sel_wdata_c;
        end
      end
      ST_GRANT0, ST_GRANT1: begin
        if (MEM_BUSYWAIT) begin
          started_d = 1'b1;
        end
        if (done_c) begin
          state_d      = ST_IDLE;
          started_d    = 1'b0;
          mem_read_d   = 1'b0;
          mem_write_d  = 1'b0;
          last_grant_d = (state_q == ST_GRANT1) ? PORT1 : PORT0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign R0_BUSYWAIT   = req0_c & ~((state_q == ST_GRANT0) & done_c);
  assign R1_BUSYWAIT   = req1_c & ~((state_q == ST_GRANT1) & done_c);
  assign READDATA      = MEM_READDATA;
  assign MEM_READ      = mem_read_q;
  assign MEM_WRITE     = mem_write_q;
  assign MEM_ADDRESS   = mem_addr_q;
  assign MEM_WRITEDATA = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural memory with a fixed busy
// latency, a scoreboard of expected transactions in grant order, and
// immediate assertions at every check point.
module tb_mem_arbiter;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;
  localparam int LAT    = 5;
  localparam int BUDGET = 100;

  typedef struct {
    logic              port;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic              CLK = 1'b0;
  logic              RESET = 1'b0;
  logic              R0_READ = 1'b0, R0_WRITE = 1'b0;
  logic [ADDR_W-1:0] R0_ADDRESS = '0;
  logic [DATA_W-1:0] R0_WRITEDATA = '0;
  logic              R0_BUSYWAIT;
  logic              R1_READ = 1'b0, R1_WRITE = 1'b0;
  logic [ADDR_W-1:0] R1_ADDRESS = '0;
  logic [DATA_W-1:0] R1_WRITEDATA = '0;
  logic              R1_BUSYWAIT;
  logic [DATA_W-1:0] READDATA;
  logic              MEM_READ, MEM_WRITE;
  logic [ADDR_W-1:0] MEM_ADDRESS;
  logic [DATA_W-1:0] MEM_WRITEDATA;
  logic [DATA_W-1:0] MEM_READDATA = '0;
  logic              MEM_BUSYWAIT = 1'b0;

  int   n_cmp = 0;
  int   n_err = 0;
  exp_t sb[$];

  logic              mem_active = 1'b0;
  int                mem_cnt = 0;
  logic              mem_init = 1'b0;
  logic [DATA_W-1:0] mem [64];

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .R0_READ(R0_READ), .R0_WRITE(R0_WRITE), .R0_ADDRESS(R0_ADDRESS),
    .R0_WRITEDATA(R0_WRITEDATA), .R0_BUSYWAIT(R0_BUSYWAIT),
    .R1_READ(R1_READ), .R1_WRITE(R1_WRITE), .R1_ADDRESS(R1_ADDRESS),
    .R1_WRITEDATA(R1_WRITEDATA), .R1_BUSYWAIT(R1_BUSYWAIT),
    .READDATA(READDATA), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DATA_W-1:0] init_word(input logic [ADDR_W-1:0] a);
    return (a == 6'h05) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(a));
  endfunction

  // Memory: busy for LAT cycles after a strobe, then releases until strobes drop.
  always @(posedge CLK) begin
    #1;
    if (!mem_init) begin
      for (int a = 0; a < 64; a++) mem[a] = init_word(6'(a));
      mem_init = 1'b1;
    end
    if (!RESET) begin
      mem_active   = 1'b0;
      mem_cnt      = 0;
      MEM_BUSYWAIT = 1'b0;
    end else if (!mem_active) begin
      if (MEM_READ || MEM_WRITE) begin
        mem_active   = 1'b1;
        mem_cnt      = LAT;
        MEM_BUSYWAIT = 1'b1;
      end
    end else if (mem_cnt != 0) begin
      mem_cnt = mem_cnt - 1;
      if (mem_cnt == 0) begin
        MEM_BUSYWAIT = 1'b0;
        if (MEM_WRITE) mem[MEM_ADDRESS] = MEM_WRITEDATA;
        else           MEM_READDATA = mem[MEM_ADDRESS];
      end
    end else if (!(MEM_READ || MEM_WRITE)) begin
      mem_active = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic port, input logic wr, input logic [ADDR_W-1:0] addr,
                      input logic [DATA_W-1:0] data);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.data = data;
    sb.push_back(e);
  endtask

  // Wait for the memory to release a transaction, then check it against the
  // oldest expectation. Before that, the non-owner must stay stalled on request.
  task automatic wait_complete(input string tag);
    exp_t       e;
    logic       found = 1'b0;
    logic [1:0] exp_bw;
    for (int i = 0; i < BUDGET && !found; i++) begin
      @(negedge CLK);
      if (mem_active && mem_cnt == 0 && (MEM_READ || MEM_WRITE)) begin
        found = 1'b1;
      end else if (sb.size() != 0) begin
        if (sb[0].port) chk({tag, "_nonowner_bw0"}, 32'(R0_BUSYWAIT), 32'(R0_READ | R0_WRITE));
        else            chk({tag, "_nonowner_bw1"}, 32'(R1_BUSYWAIT), 32'(R1_READ | R1_WRITE));
      end
    end
    chk({tag, "_completed"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        exp_bw = e.port ? {1'b0, R0_READ | R0_WRITE} : {R1_READ | R1_WRITE, 1'b0};
        chk({tag, "_busywait"}, 32'({R1_BUSYWAIT, R0_BUSYWAIT}), 32'(exp_bw));
        chk({tag, "_addr"}, 32'(MEM_ADDRESS), 32'(e.addr));
        chk({tag, "_op"}, 32'({MEM_WRITE, MEM_READ}), e.wr ? 32'd2 : 32'd1);
        if (e.wr) chk({tag, "_wdata"}, MEM_WRITEDATA, e.data);
        else      chk({tag, "_rdata"}, READDATA, e.data);
      end
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
  endtask

  initial begin
    // Reset state; a held request stays stalled during reset.
    R0_READ = 1'b1;
    #1;
    chk("rst_mem_read", 32'(MEM_READ), 32'd0);
    chk("rst_mem_write", 32'(MEM_WRITE), 32'd0);
    chk("rst_mem_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
    chk("rst_bw0_held", 32'(R0_BUSYWAIT), 32'd1);
    chk("rst_bw1_idle", 32'(R1_BUSYWAIT), 32'd0);
    R0_READ = 1'b0;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;

    // Single read with one-cycle grant latency.
    tick();
    R0_READ = 1'b1; R0_ADDRESS = 6'h05;
    push(1'b0, 1'b0, 6'h05, 32'hDEADBEEF);
    @(negedge CLK);
    chk("rd_no_strobe_yet", 32'(MEM_READ), 32'd0);
    chk("rd_bw0_stalled", 32'(R0_BUSYWAIT), 32'd1);
    @(negedge CLK);
    chk("rd_strobe", 32'(MEM_READ), 32'd1);
    chk("rd_addr", 32'(MEM_ADDRESS), 32'h05);
    wait_complete("single_rd");
    tick();
    R0_READ = 1'b0;
    @(negedge CLK);
    chk("rd_idle_strobe", 32'(MEM_READ), 32'd0);
    chk("rd_addr_held", 32'(MEM_ADDRESS), 32'h05);

    // Tie after reset: port 0 first, then port 1's write.
    do_reset();
    tick();
    R0_READ = 1'b1; R0_ADDRESS = 6'h01;
    R1_WRITE = 1'b1; R1_ADDRESS = 6'h02; R1_WRITEDATA = 32'h12345678;
    push(1'b0, 1'b0, 6'h01, 32'hA500_0001);
    push(1'b1, 1'b1, 6'h02, 32'h12345678);
    wait_complete("tie_p0");
    tick();
    R0_READ = 1'b0;
    wait_complete("tie_p1");
    tick();
    R1_WRITE = 1'b0;

    // Continuous contention: grants alternate 0,1,0,1.
    tick();
    R0_READ = 1'b1; R0_ADDRESS = 6'h02;
    R1_WRITE = 1'b1; R1_ADDRESS = 6'h03; R1_WRITEDATA = 32'hCAFE0001;
    push(1'b0, 1'b0, 6'h02, 32'h12345678);
    push(1'b1, 1'b1, 6'h03, 32'hCAFE0001);
    push(1'b0, 1'b0, 6'h02, 32'h12345678);
    push(1'b1, 1'b1, 6'h03, 32'hCAFE0001);
    for (int k = 0; k < 4; k++) wait_complete($sformatf("cont%0d", k));
    tick();
    R0_READ = 1'b0; R1_WRITE = 1'b0;

    // Address change while granted has no effect.
    tick();
    R1_READ = 1'b1; R1_ADDRESS = 6'h10;
    push(1'b1, 1'b0, 6'h10, 32'hA500_0010);
    repeat (2) @(negedge CLK);
    R1_ADDRESS = 6'h3F;
    @(negedge CLK);
    chk("chg_addr_latched", 32'(MEM_ADDRESS), 32'h10);
    wait_complete("chg");
    tick();
    R1_READ = 1'b0;
    @(negedge CLK);
    chk("chg_addr_hold_idle", 32'(MEM_ADDRESS), 32'h10);

    // Reset mid-transaction: strobe drops at once, requester stays stalled.
    tick();
    R0_READ = 1'b1; R0_ADDRESS = 6'h0A;
    push(1'b0, 1'b0, 6'h0A, 32'hA500_000A);
    repeat (3) @(negedge CLK);
    chk("mid_busy", 32'(MEM_BUSYWAIT), 32'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("mid_rst_read", 32'(MEM_READ), 32'd0);
    chk("mid_rst_addr", 32'(MEM_ADDRESS), 32'd0);
    chk("mid_rst_bw0", 32'(R0_BUSYWAIT), 32'd1);
    @(negedge CLK);
    chk("mid_rst_bw0_hold", 32'(R0_BUSYWAIT), 32'd1);
    RESET = 1'b1;
    wait_complete("mid_regrant");
    tick();
    R0_READ = 1'b0;

    // READ+WRITE together is a read.
    tick();
    R0_READ = 1'b1; R0_WRITE = 1'b1; R0_ADDRESS = 6'h07; R0_WRITEDATA = 32'h00000BAD;
    push(1'b0, 1'b0, 6'h07, 32'hA500_0007);
    @(negedge CLK);
    @(negedge CLK);
    chk("rw_read", 32'(MEM_READ), 32'd1);
    chk("rw_write", 32'(MEM_WRITE), 32'd0);
    wait_complete("rw");
    tick();
    R0_READ = 1'b0; R0_WRITE = 1'b0;
    repeat (2) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
